// File: rtl/stopwatch_display.sv
// Display back end for the stopwatch: snapshots hh/mm/ss/xx once per scan frame,
// converts them to decimal digits by repeated subtract-by-ten and scans them out as hh.mm.ss.xx.
module stopwatch_display #(
    parameter int SCAN_DIV = 100000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic [7:0] xx,
    input  logic       freeze,
    input  logic       blank,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       busy
);

    localparam int DW = (SCAN_DIV > 32'sd1) ? $clog2(SCAN_DIV) : 32'sd1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 32'sd1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CONV  = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    // Active-low gfedcba patterns for the decimal digits.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    logic [DW-1:0]   div_cnt_r;
    logic [2:0]      scan_idx_r;
    state_t          state_r;
    state_t          state_nxt_s;
    state_t          adv_state_s;
    logic [1:0]      k_r;
    logic [1:0]      k_nxt_s;
    logic [7:0]      rem_r;
    logic [7:0]      rem_nxt_s;
    logic [3:0]      tens_r;
    logic [3:0]      tens_nxt_s;
    logic [3:0][7:0] snap_r;
    logic [3:0][3:0] stage_tens_r;
    logic [3:0][3:0] stage_ones_r;
    logic [3:0]      stage_ovf_r;
    logic [3:0][3:0] disp_tens_r;
    logic [3:0][3:0] disp_ones_r;
    logic [3:0]      disp_ovf_r;
    logic            busy_r;
    logic [7:0]      an_r;
    logic [7:0]      seg_r;

    logic            div_last_s;
    logic            frame_start_s;
    logic            snap_take_s;
    logic            wr_en_s;
    logic [3:0]      wr_tens_s;
    logic [3:0]      wr_ones_s;
    logic            wr_ovf_s;
    logic            disp_load_s;
    logic [1:0]      fld_s;
    logic [3:0]      dig_s;
    logic            dp_s;
    logic [7:0]      an_nxt_s;
    logic [7:0]      seg_nxt_s;

    assign div_last_s    = (div_cnt_r == DIV_LAST);
    assign frame_start_s = div_last_s && (scan_idx_r == 3'd7);
    assign snap_take_s   = frame_start_s && !freeze && (state_r == ST_IDLE);

    // Scan divider and digit index; wraps with no dead cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r  <= '0;
            scan_idx_r <= 3'd0;
        end else if (div_last_s) begin
            div_cnt_r  <= '0;
            scan_idx_r <= scan_idx_r + 3'd1;
        end else begin
            div_cnt_r  <= div_cnt_r + DIV_ONE;
        end
    end

    // Converter state register; busy mirrors the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Converter next-state logic and staging-write controls.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        rem_nxt_s   = rem_r;
        tens_nxt_s  = tens_r;
        wr_en_s     = 1'b0;
        wr_tens_s   = 4'd0;
        wr_ones_s   = 4'd0;
        wr_ovf_s    = 1'b0;
        disp_load_s = 1'b0;
        adv_state_s = (k_r == 2'd3) ? ST_STORE : ST_LOAD;
        case (state_r)
            ST_IDLE: begin
                if (snap_take_s) begin
                    state_nxt_s = ST_LOAD;
                    k_nxt_s     = 2'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rem_nxt_s  = snap_r[k_r];
                tens_nxt_s = 4'd0;
                if (snap_r[k_r] > 8'd99) begin
                    wr_en_s     = 1'b1;
                    wr_ovf_s    = 1'b1;
                    state_nxt_s = adv_state_s;
                    k_nxt_s     = k_r + 2'd1;
                end else if (snap_r[k_r] >= 8'd10) begin
                    state_nxt_s = ST_CONV;
                end else begin
                    wr_en_s     = 1'b1;
                    wr_ones_s   = snap_r[k_r][3:0];
                    state_nxt_s = adv_state_s;
                    k_nxt_s     = k_r + 2'd1;
                end
            end
            ST_CONV: begin
                rem_nxt_s  = rem_r - 8'd10;
                tens_nxt_s = tens_r + 4'd1;
                // Digit pair is final on the step that drops rem below ten.
                if (rem_nxt_s < 8'd10) begin
                    wr_en_s     = 1'b1;
                    wr_tens_s   = tens_nxt_s;
                    wr_ones_s   = rem_nxt_s[3:0];
                    state_nxt_s = adv_state_s;
                    k_nxt_s     = k_r + 2'd1;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_STORE: begin
                disp_load_s = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Converter datapath: snapshot, working registers, staging and display copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r          <= 2'd0;
            rem_r        <= 8'd0;
            tens_r       <= 4'd0;
            snap_r       <= '0;
            stage_tens_r <= '0;
            stage_ones_r <= '0;
            stage_ovf_r  <= 4'd0;
            disp_tens_r  <= '0;
            disp_ones_r  <= '0;
            disp_ovf_r   <= 4'd0;
        end else begin
            k_r    <= k_nxt_s;
            rem_r  <= rem_nxt_s;
            tens_r <= tens_nxt_s;
            if (snap_take_s) begin
                snap_r <= {xx, ss, mm, hh};
            end
            if (wr_en_s) begin
                stage_tens_r[k_r] <= wr_tens_s;
                stage_ones_r[k_r] <= wr_ones_s;
                stage_ovf_r[k_r]  <= wr_ovf_s;
            end
            // All eight digits move together so a frame never shows a mix.
            if (disp_load_s) begin
                disp_tens_r <= stage_tens_r;
                disp_ones_r <= stage_ones_r;
                disp_ovf_r  <= stage_ovf_r;
            end
        end
    end

    // Digit selection and segment decode for the current scan position.
    always_comb begin
        fld_s    = ~scan_idx_r[2:1];
        dig_s    = scan_idx_r[0] ? disp_tens_r[fld_s] : disp_ones_r[fld_s];
        dp_s     = !scan_idx_r[0] && (scan_idx_r != 3'd0);
        if (disp_ovf_r[fld_s]) begin
            seg_nxt_s = {!dp_s, 7'b0111111};
        end else if (LZ_BLANK && (scan_idx_r == 3'd7) && (dig_s == 4'd0)) begin
            seg_nxt_s = {!dp_s, 7'h7F};
        end else begin
            seg_nxt_s = {!dp_s, seg7(dig_s)};
        end
        if (blank) begin
            an_nxt_s = 8'hFF;
        end else begin
            an_nxt_s = ~(8'h01 << scan_idx_r);
        end
    end

    // Registered display drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= 8'hFF;
            seg_r <= 8'hFF;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign an   = an_r;
    assign seg  = seg_r;
    assign busy = busy_r;

endmodule
